// File: rtl/alu_bitop_seq.sv
// alu_bitop_seq
//   Bit-manipulation unit for the CB-prefix BIT/RES/SET operations on one byte.
//   The default build is nibble-serial: the operation takes one M-cycle
//   (IDLE -> CAP -> LO -> HI), and a start in the done cycle chains the next
//   operation with no gap.
//   Build option ALU_BITOP_FAST_EN: CAP/LO/HI collapse into one EXEC state.
//   That build returns a result the cycle after start and can take one
//   operation per cycle.
//
// Ports
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   start    in   request, sampled in IDLE and in the done cycle
//   op       in   [1:0] 00 BIT, 01 RES, 10 SET, 11 reserved (pass-through)
//   bit_sel  in   [2:0] bit index
//   opa      in   [7:0] operand byte
//   busy     out  operation in flight (always 0 in the fast build)
//   done     out  one-cycle completion pulse
//   res      out  [7:0] result byte, held until the next completion
//   res_we   out  result write strobe, RES/SET only
//   flag_z   out  Z flag (inverted tested bit), valid with flag_we
//   flag_n   out  N flag, cleared by BIT
//   flag_h   out  H flag, set by BIT
//   flag_we  out  flag write strobe, BIT only
module alu_bitop_seq (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [2:0] bit_sel,
    input  logic [7:0] opa,
    output logic       busy,
    output logic       done,
    output logic [7:0] res,
    output logic       res_we,
    output logic       flag_z,
    output logic       flag_n,
    output logic       flag_h,
    output logic       flag_we
);

    localparam logic [1:0] OP_BIT = 2'b00;
    localparam logic [1:0] OP_RES = 2'b01;
    localparam logic [1:0] OP_SET = 2'b10;

`ifdef ALU_BITOP_FAST_EN
    typedef enum logic {S_IDLE, S_EXEC} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_CAP, S_LO, S_HI} state_t;
`endif

    state_t     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] opa_q, opa_d;
    logic [7:0] res_q, res_d;
    logic       fz_q, fz_d;
    logic       fn_q, fn_d;
    logic       fh_q, fh_d;
    logic       accept;
    logic       final_cyc;

    // Apply the operation to one nibble; BIT and reserved leave data unchanged.
    function automatic logic [3:0] nib_apply(input logic [1:0] o,
                                             input logic [3:0] a,
                                             input logic [3:0] m);
        case (o)
            OP_RES:  return a & ~m;
            OP_SET:  return a | m;
            default: return a;
        endcase
    endfunction

`ifdef ALU_BITOP_FAST_EN
    logic [7:0] mask;
    logic       tbit;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sel_d   = sel_q;
        opa_d   = opa_q;
        res_d   = res_q;
        fz_d    = fz_q;
        fn_d    = fn_q;
        fh_d    = fh_q;
        mask    = 8'h01 << sel_q;
        tbit    = opa_q[sel_q];
        accept  = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: accept = start;
            S_EXEC: begin
                res_d   = {nib_apply(op_q, opa_q[7:4], mask[7:4]),
                           nib_apply(op_q, opa_q[3:0], mask[3:0])};
                done    = 1'b1;
                state_d = S_IDLE;
                accept  = start;
            end
            default: state_d = S_IDLE;
        endcase
        if (done && op_q == OP_BIT) begin
            fz_d = ~tbit;
            fn_d = 1'b0;
            fh_d = 1'b1;
        end
        if (accept) begin
            op_d    = op;
            sel_d   = bit_sel;
            opa_d   = opa;
            state_d = S_EXEC;
        end
    end

    assign busy      = 1'b0;
    assign final_cyc = (state_q == S_EXEC);
`else
    logic [7:0] mask_q, mask_d;
    logic       tbit_q, tbit_d;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sel_d   = sel_q;
        opa_d   = opa_q;
        mask_d  = mask_q;
        tbit_d  = tbit_q;
        res_d   = res_q;
        fz_d    = fz_q;
        fn_d    = fn_q;
        fh_d    = fh_q;
        accept  = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: accept = start;
            S_CAP: begin
                mask_d  = 8'h01 << sel_q;
                state_d = S_LO;
            end
            S_LO: begin
                res_d[3:0] = nib_apply(op_q, opa_q[3:0], mask_q[3:0]);
                if (!sel_q[2]) tbit_d = |(opa_q[3:0] & mask_q[3:0]);
                state_d = S_HI;
            end
            S_HI: begin
                res_d[7:4] = nib_apply(op_q, opa_q[7:4], mask_q[7:4]);
                if (sel_q[2]) tbit_d = |(opa_q[7:4] & mask_q[7:4]);
                done    = 1'b1;
                state_d = S_IDLE;
                // A start in the done cycle chains the next operation directly.
                accept  = start;
            end
            default: state_d = S_IDLE;
        endcase
        if (done && op_q == OP_BIT) begin
            fz_d = ~tbit_d;
            fn_d = 1'b0;
            fh_d = 1'b1;
        end
        if (accept) begin
            op_d    = op;
            sel_d   = bit_sel;
            opa_d   = opa;
            state_d = S_CAP;
        end
    end

    // Operand/mask registers are pure data: loaded before use, no reset needed.
    always_ff @(posedge clk) begin
        mask_q <= mask_d;
        tbit_q <= tbit_d;
    end

    assign busy      = (state_q != S_IDLE);
    assign final_cyc = (state_q == S_HI);
`endif

    always_ff @(posedge clk) begin
        op_q  <= op_d;
        sel_q <= sel_d;
        opa_q <= opa_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            res_q   <= 8'h00;
            fz_q    <= 1'b0;
            fn_q    <= 1'b0;
            fh_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            fz_q    <= fz_d;
            fn_q    <= fn_d;
            fh_q    <= fh_d;
        end
    end

    // The final nibble/flags are presented in the done cycle itself and
    // captured at its end, so res and flags are valid with the strobes.
    assign res     = final_cyc ? res_d : res_q;
    assign flag_z  = final_cyc ? fz_d  : fz_q;
    assign flag_n  = final_cyc ? fn_d  : fn_q;
    assign flag_h  = final_cyc ? fh_d  : fh_q;
    assign res_we  = done && (op_q == OP_RES || op_q == OP_SET);
    assign flag_we = done && (op_q == OP_BIT);

endmodule

// File: tb/tb_alu_bitop_seq.sv
module tb_alu_bitop_seq;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [1:0] op;
    logic [2:0] bit_sel;
    logic [7:0] opa;
    logic       busy, done, res_we, flag_z, flag_n, flag_h, flag_we;
    logic [7:0] res;

    int total = 0;
    int bad   = 0;

    alu_bitop_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .bit_sel (bit_sel),
        .opa     (opa),
        .busy    (busy),
        .done    (done),
        .res     (res),
        .res_we  (res_we),
        .flag_z  (flag_z),
        .flag_n  (flag_n),
        .flag_h  (flag_h),
        .flag_we (flag_we)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},    {31'd0, busy},    0);
        chk({tag, "_done"},    {31'd0, done},    0);
        chk({tag, "_res"},     {24'd0, res},     0);
        chk({tag, "_res_we"},  {31'd0, res_we},  0);
        chk({tag, "_flag_z"},  {31'd0, flag_z},  0);
        chk({tag, "_flag_n"},  {31'd0, flag_n},  0);
        chk({tag, "_flag_h"},  {31'd0, flag_h},  0);
        chk({tag, "_flag_we"}, {31'd0, flag_we}, 0);
    endtask

    // Issue one operation from IDLE and check it cycle by cycle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [2:0] s,
                          input logic [7:0] a, input logic [7:0] er, input logic ewe,
                          input logic efwe, input logic ez, input logic eh);
        op = o; bit_sel = s; opa = a; start = 1'b1;
        tick();                       // cycle N+1
        start = 1'b0;
`ifdef ALU_BITOP_FAST_EN
        chk({tag, "_done"},    {31'd0, done},    1);
        chk({tag, "_busy"},    {31'd0, busy},    0);
`else
        chk({tag, "_busy1"},   {31'd0, busy},    1);
        chk({tag, "_done1"},   {31'd0, done},    0);
        tick();                       // N+2
        chk({tag, "_done2"},   {31'd0, done},    0);
        tick();                       // N+3
        chk({tag, "_done"},    {31'd0, done},    1);
        chk({tag, "_busy3"},   {31'd0, busy},    1);
`endif
        chk({tag, "_res"},     {24'd0, res},     {24'd0, er});
        chk({tag, "_res_we"},  {31'd0, res_we},  {31'd0, ewe});
        chk({tag, "_flag_we"}, {31'd0, flag_we}, {31'd0, efwe});
        chk({tag, "_flag_z"},  {31'd0, flag_z},  {31'd0, ez});
        chk({tag, "_flag_n"},  {31'd0, flag_n},  0);
        chk({tag, "_flag_h"},  {31'd0, flag_h},  {31'd0, eh});
        tick();
        chk({tag, "_after_done"}, {31'd0, done}, 0);
        chk({tag, "_after_busy"}, {31'd0, busy}, 0);
        chk({tag, "_held_res"},   {24'd0, res},  {24'd0, er});
    endtask

    logic [7:0] res_tbl [8];

    initial begin
        res_tbl = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        reset_n = 1'b0; start = 1'b0; op = 2'b00; bit_sel = 3'd0; opa = 8'h00;
        #1;
        chk_idle_outputs("reset");
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk_idle_outputs("post_reset");

        // RES sweep on FF
        for (int i = 0; i < 8; i++)
            run_op($sformatf("res_sweep%0d", i), 2'b01, 3'(i), 8'hFF, res_tbl[i], 1'b1, 1'b0, 1'b0, 1'b0);

        // SET on 00 and on A5, RES on A5
        run_op("set0",  2'b10, 3'd0, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("set3",  2'b10, 3'd3, 8'h00, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("set4",  2'b10, 3'd4, 8'h00, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("set7",  2'b10, 3'd7, 8'h00, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("setA5", 2'b10, 3'd7, 8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("resA5", 2'b01, 3'd7, 8'hA5, 8'h25, 1'b1, 1'b0, 1'b0, 1'b0);

        // BIT on A5 = 1010_0101
        run_op("bit0", 2'b00, 3'd0, 8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1);
        run_op("bit1", 2'b00, 3'd1, 8'hA5, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);
        run_op("bit6", 2'b00, 3'd6, 8'hA5, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);

        // Reserved op: pass-through, no strobes, flags held from bit6
        run_op("rsvd", 2'b11, 3'd3, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
        // RES keeps flags held too
        run_op("res_flaghold", 2'b01, 3'd5, 8'hFF, 8'hDF, 1'b1, 1'b0, 1'b1, 1'b1);

`ifndef ALU_BITOP_FAST_EN
        // Busy rejection and back-to-back start in the done cycle
        op = 2'b10; bit_sel = 3'd2; opa = 8'h00; start = 1'b1;
        tick();                               // N+1
        op = 2'b01; bit_sel = 3'd0; opa = 8'hFF; start = 1'b1;
        chk("rej_done1", {31'd0, done}, 0);
        tick();                               // N+2
        chk("rej_done2", {31'd0, done}, 0);
        tick();                               // N+3, start still high
        chk("rej_done3", {31'd0, done}, 1);
        chk("rej_res3",  {24'd0, res},  32'h04);
        chk("rej_we3",   {31'd0, res_we}, 1);
        tick();                               // N+4
        start = 1'b0;
        chk("b2b_busy4", {31'd0, busy}, 1);
        chk("b2b_done4", {31'd0, done}, 0);
        chk("b2b_res4",  {24'd0, res},  32'h04);
        tick();                               // N+5
        chk("b2b_done5", {31'd0, done}, 0);
        tick();                               // N+6
        chk("b2b_done6", {31'd0, done}, 1);
        chk("b2b_res6",  {24'd0, res},  32'hFE);
        chk("b2b_we6",   {31'd0, res_we}, 1);
        tick();
        chk("b2b_idle",  {31'd0, busy}, 0);
        chk("b2b_done7", {31'd0, done}, 0);

        // Reset mid-operation
        op = 2'b00; bit_sel = 3'd1; opa = 8'hA5; start = 1'b1;
        tick();                               // N+1
        start = 1'b0;
        tick();                               // N+2
        reset_n = 1'b0;
        #1;
        chk_idle_outputs("midrst");
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("midrst_nodone%0d", i), {31'd0, done}, 0);
            chk($sformatf("midrst_nobusy%0d", i), {31'd0, busy}, 0);
        end
        run_op("post_rst_set7", 2'b10, 3'd7, 8'h00, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
`else
        // Fast build: RES sweep with start held high, one done per cycle
        op = 2'b01; opa = 8'hFF; bit_sel = 3'd0; start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i < 7) bit_sel = 3'(i + 1);
            else start = 1'b0;
            chk($sformatf("fast_done%0d", i), {31'd0, done}, 1);
            chk($sformatf("fast_res%0d", i),  {24'd0, res},  {24'd0, res_tbl[i]});
            chk($sformatf("fast_busy%0d", i), {31'd0, busy}, 0);
        end
        tick();
        chk("fast_end_done", {31'd0, done}, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
